// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson counter decoder: FSM states,
// the legal 4-bit code table (entry i is the code for position i) and widths.
package johnson_pkg;

  localparam int JC_WIDTH = 4;
  localparam int JC_POSITIONS = 8;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } jd_state_e;

  // Element 0 is the rightmost entry of the concatenation.
  localparam logic [JC_POSITIONS-1:0][JC_WIDTH-1:0] JC_TABLE = {
    4'b1000, 4'b1100, 4'b1110, 4'b1111,
    4'b0111, 4'b0011, 4'b0001, 4'b0000
  };

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational map from a received Johnson code to {legal, index}.
// Illegal codes report index 0; the caller decides what to hold.
module johnson_code_lut
  import johnson_pkg::*;
(
  input  logic [JC_WIDTH-1:0] code,
  output logic                legal,
  output logic [2:0]          index
);

  always_comb begin
    legal = 1'b0;
    index = 3'd0;
    for (int i = 0; i < JC_POSITIONS; i++) begin
      if (code == JC_TABLE[i]) begin
        legal = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter decoder with sequence tracking: decodes each sampled code,
// acquires lock after LOCK_COUNT correct steps and drops it after MISS_LIMIT misses.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [JC_WIDTH-1:0] q_in,
  output logic [2:0]          index,
  output logic [7:0]          onehot,
  output logic                code_ok,
  output logic                locked,
  output logic                seq_err,
  output logic [7:0]          err_count
);

  localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);

  jd_state_e         state_q, state_d;
  logic [2:0]        exp_q, exp_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
  logic [2:0]        index_q, index_d;
  logic [7:0]        onehot_q, onehot_d;
  logic              code_ok_q, code_ok_d;
  logic              locked_q, locked_d;
  logic              seq_err_q, seq_err_d;
  logic [7:0]        err_count_q, err_count_d;

  logic       lut_legal;
  logic [2:0] lut_index;
  logic [2:0] lut_next;
  logic       hit;

  johnson_code_lut u_lut (
    .code  (q_in),
    .legal (lut_legal),
    .index (lut_index)
  );

  assign lut_next = lut_index + 3'd1;
  assign hit      = lut_legal && (lut_index == exp_q);
  assign good_inc = good_q + GOOD_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    good_d      = good_q;
    miss_d      = miss_q;
    index_d     = index_q;
    onehot_d    = onehot_q;
    code_ok_d   = code_ok_q;
    err_count_d = err_count_q;
    seq_err_d   = 1'b0;

    if (sample_en) begin
      code_ok_d = lut_legal;
      onehot_d  = lut_legal ? (8'd1 << lut_index) : 8'd0;
      if (lut_legal) index_d = lut_index;

      unique case (state_q)
        ST_UNLOCKED: begin
          if (lut_legal) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
            exp_d   = lut_next;
          end
        end
        ST_ACQUIRE: begin
          if (hit) begin
            exp_d = lut_next;
            if (good_inc == GOOD_W'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              miss_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
            if (lut_legal) exp_d = lut_next;
            else           state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            miss_d = '0;
            exp_d  = lut_next;
          end else begin
            seq_err_d   = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            // A legal but unexpected code re-anchors; an illegal one just advances.
            exp_d       = lut_legal ? lut_next : exp_q + 3'd1;
            if (miss_inc == MISS_W'(MISS_LIMIT)) begin
              state_d = ST_UNLOCKED;
              miss_d  = '0;
              good_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      exp_q       <= 3'd0;
      good_q      <= '0;
      miss_q      <= '0;
      index_q     <= 3'd0;
      onehot_q    <= 8'd0;
      code_ok_q   <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      index_q     <= index_d;
      onehot_q    <= onehot_d;
      code_ok_q   <= code_ok_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign index     = index_q;
  assign onehot    = onehot_q;
  assign code_ok   = code_ok_q;
  assign locked    = locked_q;
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: a table of hand-computed vectors
// followed by an error-count saturation soak and a final reset check.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [3:0] q_in;
  logic [2:0] index;
  logic [7:0] onehot;
  logic       code_ok;
  logic       locked;
  logic       seq_err;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  johnson_decoder #(.LOCK_COUNT(3), .MISS_LIMIT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .q_in      (q_in),
    .index     (index),
    .onehot    (onehot),
    .code_ok   (code_ok),
    .locked    (locked),
    .seq_err   (seq_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] q;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       ok;
    logic       lk;
    logic       se;
    logic [7:0] ec;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [3:0] q);
    reset     = r;
    sample_en = en;
    q_in      = q;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic en, input logic [3:0] q,
                     input logic [2:0] idx, input logic [7:0] oh, input logic ok,
                     input logic lk, input logic se, input logic [7:0] ec);
    vq.push_back('{rst: r, en: en, q: q, idx: idx, oh: oh, ok: ok, lk: lk, se: se, ec: ec});
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; q_in = 4'b0000;

    //   rst en  q        idx  onehot        ok lk se ec
    add(1, 1, 4'b0111, 0, 8'b0000_0000, 0, 0, 0, 0);  // reset overrides sample_en
    add(1, 0, 4'b0000, 0, 8'b0000_0000, 0, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 8'b0000_0001, 1, 0, 0, 0);  // acquire
    add(0, 1, 4'b0001, 1, 8'b0000_0010, 1, 0, 0, 0);
    add(0, 1, 4'b0011, 2, 8'b0000_0100, 1, 0, 0, 0);
    add(0, 1, 4'b0111, 3, 8'b0000_1000, 1, 1, 0, 0);  // locked on 4th sample
    add(0, 1, 4'b1111, 4, 8'b0001_0000, 1, 1, 0, 0);
    add(0, 1, 4'b1110, 5, 8'b0010_0000, 1, 1, 0, 0);
    add(0, 1, 4'b1100, 6, 8'b0100_0000, 1, 1, 0, 0);
    add(0, 1, 4'b1000, 7, 8'b1000_0000, 1, 1, 0, 0);
    add(0, 1, 4'b0000, 0, 8'b0000_0001, 1, 1, 0, 0);  // wrap 7 -> 0
    add(0, 0, 4'b0101, 0, 8'b0000_0001, 1, 1, 0, 0);  // sample_en low: hold
    add(0, 0, 4'b1111, 0, 8'b0000_0001, 1, 1, 0, 0);
    add(0, 0, 4'b1000, 0, 8'b0000_0001, 1, 1, 0, 0);
    add(0, 1, 4'b0001, 1, 8'b0000_0010, 1, 1, 0, 0);  // resume
    add(0, 1, 4'b0011, 2, 8'b0000_0100, 1, 1, 0, 0);
    add(0, 1, 4'b0101, 2, 8'b0000_0000, 0, 1, 1, 1);  // single illegal code
    add(0, 1, 4'b1111, 4, 8'b0001_0000, 1, 1, 0, 1);  // exp advanced past it
    add(0, 1, 4'b0101, 4, 8'b0000_0000, 0, 1, 1, 2);
    add(0, 1, 4'b0101, 4, 8'b0000_0000, 0, 0, 1, 3);  // 2nd miss unlocks
    add(0, 1, 4'b0101, 4, 8'b0000_0000, 0, 0, 0, 3);  // no seq_err when unlocked
    add(0, 1, 4'b1100, 6, 8'b0100_0000, 1, 0, 0, 3);
    add(0, 1, 4'b0000, 0, 8'b0000_0001, 1, 0, 0, 3);  // re-anchor in acquire
    add(0, 1, 4'b0001, 1, 8'b0000_0010, 1, 0, 0, 3);
    add(0, 1, 4'b0011, 2, 8'b0000_0100, 1, 0, 0, 3);
    add(0, 1, 4'b0010, 2, 8'b0000_0000, 0, 0, 0, 3);  // illegal in acquire
    add(0, 1, 4'b0011, 2, 8'b0000_0100, 1, 0, 0, 3);
    add(0, 1, 4'b0111, 3, 8'b0000_1000, 1, 0, 0, 3);
    add(0, 1, 4'b1111, 4, 8'b0001_0000, 1, 0, 0, 3);
    add(0, 1, 4'b1110, 5, 8'b0010_0000, 1, 1, 0, 3);
    add(1, 1, 4'b1100, 0, 8'b0000_0000, 0, 0, 0, 0);  // reset mid-lock
    add(0, 1, 4'b1100, 6, 8'b0100_0000, 1, 0, 0, 0);
    add(0, 1, 4'b1000, 7, 8'b1000_0000, 1, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 8'b0000_0001, 1, 0, 0, 0);
    add(0, 1, 4'b0001, 1, 8'b0000_0010, 1, 1, 0, 0);  // full reacquisition
    add(0, 1, 4'b0001, 1, 8'b0000_0010, 1, 1, 1, 1);  // repeated code is a miss
    add(0, 1, 4'b0011, 2, 8'b0000_0100, 1, 1, 0, 1);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].q);
      chk($sformatf("v%0d.index", i),     index,     vq[i].idx);
      chk($sformatf("v%0d.onehot", i),    onehot,    vq[i].oh);
      chk($sformatf("v%0d.code_ok", i),   code_ok,   vq[i].ok);
      chk($sformatf("v%0d.locked", i),    locked,    vq[i].lk);
      chk($sformatf("v%0d.seq_err", i),   seq_err,   vq[i].se);
      chk($sformatf("v%0d.err_count", i), err_count, vq[i].ec);
    end

    // Saturation soak: 150 rounds of lock then two misses = 300 errors.
    step(1, 0, 4'b0000);
    for (int r = 1; r <= 150; r++) begin
      step(0, 1, 4'b0000);
      step(0, 1, 4'b0001);
      step(0, 1, 4'b0011);
      step(0, 1, 4'b0111);
      chk($sformatf("soak%0d.locked", r), locked, 1);
      step(0, 1, 4'b0101);
      chk($sformatf("soak%0d.seq_err1", r), seq_err, 1);
      step(0, 1, 4'b0101);
      chk($sformatf("soak%0d.unlocked", r), locked, 0);
      chk($sformatf("soak%0d.err_count", r), err_count, (2 * r > 255) ? 255 : 2 * r);
    end

    step(1, 1, 4'b0001);
    chk("final.index",     index,     0);
    chk("final.onehot",    onehot,    0);
    chk("final.code_ok",   code_ok,   0);
    chk("final.locked",    locked,    0);
    chk("final.seq_err",   seq_err,   0);
    chk("final.err_count", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
